// File: rtl/differentiator16_if.sv
// Stream interface of differentiator16: sample input with valid/ready,
// delta output with valid/ready and, when DIFF16_COUNT_EN is defined,
// the accepted-sample counter.
interface differentiator16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_out;
`ifdef DIFF16_COUNT_EN
  logic [15:0] count;
`endif

  // Producer/consumer side (drives samples, accepts deltas)
  modport master (
    output in_valid, in_acc, out_ready,
    input  in_ready, out_valid, data_out
`ifdef DIFF16_COUNT_EN
    , input count
`endif
  );

  // Differentiator side
  modport slave (
    input  in_valid, in_acc, out_ready,
    output in_ready, out_valid, data_out
`ifdef DIFF16_COUNT_EN
    , output count
`endif
  );
endinterface

// File: rtl/differentiator16.sv
// differentiator16: turns a running-sum stream back into increments
// (in_acc - previous accepted sample, modulo 2^16) through a 2-entry
// output FIFO. Optional accepted-sample counter enabled by the macro
// DIFF16_COUNT_EN.
module differentiator16 (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  differentiator16_if.slave  bus
);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

  occ_t        r_occ;
  logic [15:0] r_head;
  logic [15:0] r_tail;
  logic [15:0] r_prev;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_accept;
  logic        w_pop;
  logic [15:0] w_delta;

  assign w_in_ready  = (r_occ != OCC_FULL) && !clr && !rst;
  assign w_out_valid = (r_occ != OCC_EMPTY);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready && !clr;
  assign w_delta     = bus.in_acc - r_prev;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.data_out  = r_head;

  // FIFO is head/tail registers rather than a pointer ring so that the
  // head (data_out) keeps its last value once the FIFO drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_occ  <= OCC_EMPTY;
      r_head <= '0;
      r_tail <= '0;
      r_prev <= '0;
    end else if (clr) begin
      r_occ  <= OCC_EMPTY;
      r_prev <= '0;
    end else begin
      if (w_accept) begin
        r_prev <= bus.in_acc;
      end
      case ({w_accept, w_pop})
        2'b10: begin
          if (r_occ == OCC_EMPTY) begin
            r_head <= w_delta;
            r_occ  <= OCC_ONE;
          end else begin
            r_tail <= w_delta;
            r_occ  <= OCC_FULL;
          end
        end
        2'b01: begin
          if (r_occ == OCC_FULL) begin
            r_head <= r_tail;
            r_occ  <= OCC_ONE;
          end else begin
            r_occ  <= OCC_EMPTY;
          end
        end
        // Push and pop together only happens at occupancy 1
        2'b11: begin
          r_head <= w_delta;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef DIFF16_COUNT_EN
  logic [15:0] r_count;

  assign bus.count = r_count;

  // Count accepted samples, wrapping silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_differentiator16.sv
// Bench for differentiator16: table of per-cycle vectors plus an
// asynchronous-reset sequence. Count checks follow DIFF16_COUNT_EN.
module tb_differentiator16;

  logic clk;
  logic rst;
  logic clr;

  differentiator16_if u_if ();

  differentiator16 u_dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [15:0] acc;
    logic        ordy;
    logic        eir;
    logic        eov;
    logic [15:0] edo;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [24];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic c, input logic iv, input logic [15:0] acc,
                              input logic ordy, input logic eir, input logic eov,
                              input logic [15:0] edo, input logic [15:0] ecnt);
    vec_t v;
    v.clr = c; v.iv = iv; v.acc = acc; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.edo = edo; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=0x%04h required=0x%04h t=%0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      clr           = tbl[i].clr;
      u_if.in_valid = tbl[i].iv;
      u_if.in_acc   = tbl[i].acc;
      u_if.out_ready = tbl[i].ordy;
      #1;
      check("in_ready", i, {15'b0, u_if.in_ready}, {15'b0, tbl[i].eir});
      @(posedge clk);
      #1;
      check("out_valid", i, {15'b0, u_if.out_valid}, {15'b0, tbl[i].eov});
      check("data_out", i, u_if.data_out, tbl[i].edo);
`ifdef DIFF16_COUNT_EN
      check("count", i, u_if.count, tbl[i].ecnt);
`endif
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    //            clr  iv   acc       ordy eir  eov  data_out  count
    // Stream 5,12,12,20 then drain
    tbl[0]  = mk(1'b0, 1'b1, 16'd5,    1'b1, 1'b1, 1'b1, 16'd5,    16'd1);
    tbl[1]  = mk(1'b0, 1'b1, 16'd12,   1'b1, 1'b1, 1'b1, 16'd7,    16'd2);
    tbl[2]  = mk(1'b0, 1'b1, 16'd12,   1'b1, 1'b1, 1'b1, 16'd0,    16'd3);
    tbl[3]  = mk(1'b0, 1'b1, 16'd20,   1'b1, 1'b1, 1'b1, 16'd8,    16'd4);
    tbl[4]  = mk(1'b0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 16'd8,    16'd4);
    // clr on empty FIFO, then wrap-around deltas
    tbl[5]  = mk(1'b1, 1'b0, 16'd0,    1'b1, 1'b0, 1'b0, 16'd8,    16'd0);
    tbl[6]  = mk(1'b0, 1'b1, 16'hFFF0, 1'b1, 1'b1, 1'b1, 16'hFFF0, 16'd1);
    tbl[7]  = mk(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 16'h0020, 16'd2);
    tbl[8]  = mk(1'b0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 16'h0020, 16'd2);
    // Stall: 3 offered, 2 accepted, then drain in order
    tbl[9]  = mk(1'b0, 1'b1, 16'h0023, 1'b0, 1'b1, 1'b1, 16'h0013, 16'd3);
    tbl[10] = mk(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b1, 16'h0013, 16'd4);
    tbl[11] = mk(1'b0, 1'b1, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h0013, 16'd4);
    tbl[12] = mk(1'b0, 1'b1, 16'h0040, 1'b1, 1'b0, 1'b1, 16'h000D, 16'd4);
    tbl[13] = mk(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 16'h000D, 16'd5);
    tbl[14] = mk(1'b0, 1'b0, 16'd0,    1'b1, 1'b0, 1'b1, 16'h0010, 16'd5);
    tbl[15] = mk(1'b0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 16'h0010, 16'd5);
    // Two buffered, clr with attempted push/pop, then 4
    tbl[16] = mk(1'b0, 1'b1, 16'd7,    1'b0, 1'b1, 1'b1, 16'hFFC7, 16'd6);
    tbl[17] = mk(1'b0, 1'b1, 16'd9,    1'b0, 1'b1, 1'b1, 16'hFFC7, 16'd7);
    tbl[18] = mk(1'b1, 1'b1, 16'd9,    1'b1, 1'b0, 1'b0, 16'hFFC7, 16'd0);
    tbl[19] = mk(1'b0, 1'b1, 16'd4,    1'b1, 1'b1, 1'b1, 16'd4,    16'd1);
    // After async reset: 30 is first sample; then push+pop at occupancy 1
    tbl[20] = mk(1'b0, 1'b1, 16'd30,   1'b1, 1'b1, 1'b1, 16'd30,   16'd1);
    tbl[21] = mk(1'b0, 1'b1, 16'd37,   1'b1, 1'b1, 1'b1, 16'd7,    16'd2);
    tbl[22] = mk(1'b0, 1'b0, 16'd0,    1'b0, 1'b1, 1'b1, 16'd7,    16'd2);
    tbl[23] = mk(1'b0, 1'b0, 16'd0,    1'b1, 1'b1, 1'b0, 16'd7,    16'd2);

    rst            = 1'b1;
    clr            = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.in_acc    = '0;
    u_if.out_ready = 1'b0;
    #1;
    check("rst_in_ready", -1, {15'b0, u_if.in_ready}, 16'd0);
    check("rst_out_valid", -1, {15'b0, u_if.out_valid}, 16'd0);
    check("rst_data_out", -1, u_if.data_out, 16'd0);
`ifdef DIFF16_COUNT_EN
    check("rst_count", -1, u_if.count, 16'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(0, 19);

    // Asynchronous reset between edges with one entry buffered
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b0;
    #2;
    check("pre_rst_out_valid", -2, {15'b0, u_if.out_valid}, 16'd1);
    rst = 1'b1;
    #1;
    check("async_out_valid", -2, {15'b0, u_if.out_valid}, 16'd0);
    check("async_data_out", -2, u_if.data_out, 16'd0);
    check("async_in_ready", -2, {15'b0, u_if.in_ready}, 16'd0);
`ifdef DIFF16_COUNT_EN
    check("async_count", -2, u_if.count, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run(20, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
